// File: rtl/t07_wb_arbiter.sv
// Writeback arbiter: grants one of INT / MEM / FPU per cycle onto a single register-file
// write port, with round-robin or fixed priority, and a registered writeback stage.
module t07_wb_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_valid,
    input  logic [2:0] int_sel,
    input  logic [4:0] int_rd,
    input  logic       mem_valid,
    input  logic [4:0] mem_rd,
    input  logic       fpu_valid,
    input  logic [4:0] fpu_rd,
    output logic       int_ready,
    output logic       mem_ready,
    output logic       fpu_ready,
    output logic       wb_en,
    output logic [2:0] wb_sel,
    output logic [4:0] wb_rd,
    output logic       stall,
    output logic       sel_err
);

    typedef enum logic [1:0] {
        PTR_INT = 2'd0,
        PTR_MEM = 2'd1,
        PTR_FPU = 2'd2
    } ptr_e;

    ptr_e       ptr_q, ptr_d;
    logic       int_sel_bad;
    logic       en_d;
    logic [2:0] sel_d;
    logic [4:0] rd_d;

    // Legal integer sources are PC (000), ALU (010) and imm (100) only.
    assign int_sel_bad = int_sel[0] | (int_sel[2] & int_sel[1]);
    assign stall       = int_valid & ~int_ready;

    always_comb begin
        int_ready = 1'b0;
        mem_ready = 1'b0;
        fpu_ready = 1'b0;
        ptr_d     = ptr_q;
        if (!rst) begin
            if (RR_EN) begin
                case (ptr_q)
                    PTR_INT: begin
                        if (int_valid)      int_ready = 1'b1;
                        else if (mem_valid) mem_ready = 1'b1;
                        else if (fpu_valid) fpu_ready = 1'b1;
                    end
                    PTR_MEM: begin
                        if (mem_valid)      mem_ready = 1'b1;
                        else if (fpu_valid) fpu_ready = 1'b1;
                        else if (int_valid) int_ready = 1'b1;
                    end
                    default: begin
                        if (fpu_valid)      fpu_ready = 1'b1;
                        else if (int_valid) int_ready = 1'b1;
                        else if (mem_valid) mem_ready = 1'b1;
                    end
                endcase
                if (int_ready)      ptr_d = PTR_MEM;
                else if (mem_ready) ptr_d = PTR_FPU;
                else if (fpu_ready) ptr_d = PTR_INT;
            end else begin
                if (mem_valid)      mem_ready = 1'b1;
                else if (fpu_valid) fpu_ready = 1'b1;
                else if (int_valid) int_ready = 1'b1;
                ptr_d = PTR_MEM;
            end
        end
    end

    // Select and address hold their last value when nothing transfers.
    always_comb begin
        en_d  = 1'b0;
        sel_d = wb_sel;
        rd_d  = wb_rd;
        if (mem_ready) begin
            sel_d = 3'b001;
            rd_d  = mem_rd;
            en_d  = |mem_rd;
        end else if (fpu_ready) begin
            sel_d = 3'b011;
            rd_d  = fpu_rd;
            en_d  = |fpu_rd;
        end else if (int_ready) begin
            sel_d = int_sel;
            rd_d  = int_rd;
            en_d  = (|int_rd) & ~int_sel_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= PTR_MEM;
            wb_en   <= 1'b0;
            wb_sel  <= 3'b000;
            wb_rd   <= 5'd0;
            sel_err <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wb_en  <= en_d;
            wb_sel <= sel_d;
            wb_rd  <= rd_d;
            if (int_ready && int_sel_bad) sel_err <= 1'b1;
        end
    end

endmodule
